// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each requester gets a one-entry response register with its own valid/ready handshake.
module alu_arbiter #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned OP_WIDTH = 10
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [OP_WIDTH-1:0] req0_op,
    input  logic [WIDTH-1:0]    req0_in1,
    input  logic [WIDTH-1:0]    req0_in2,
    output logic                resp0_valid,
    input  logic                resp0_ready,
    output logic [WIDTH-1:0]    resp0_data,

    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [OP_WIDTH-1:0] req1_op,
    input  logic [WIDTH-1:0]    req1_in1,
    input  logic [WIDTH-1:0]    req1_in2,
    output logic                resp1_valid,
    input  logic                resp1_ready,
    output logic [WIDTH-1:0]    resp1_data,

    output logic [WIDTH-1:0]    alu_in1,
    output logic [WIDTH-1:0]    alu_in2,
    output logic [OP_WIDTH-1:0] alu_op,
    input  logic [WIDTH-1:0]    alu_out
);

    logic last_q;
    logic resp0_valid_q, resp1_valid_q;
    logic [WIDTH-1:0] resp0_data_q, resp1_data_q;
    logic elig0, elig1;
    logic grant0, grant1;

    // A full slot being drained this cycle counts as free.
    assign elig0 = req0_valid & (~resp0_valid_q | resp0_ready);
    assign elig1 = req1_valid & (~resp1_valid_q | resp1_ready);

    // last_q == 1 means requester 0 wins a tie.
    assign grant0 = ~reset & elig0 & (~elig1 | last_q);
    assign grant1 = ~reset & elig1 & (~elig0 | ~last_q);

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign resp0_valid = resp0_valid_q;
    assign resp1_valid = resp1_valid_q;
    assign resp0_data  = resp0_data_q;
    assign resp1_data  = resp1_data_q;

    always_comb begin
        alu_in1 = '0;
        alu_in2 = '0;
        alu_op  = '0;
        if (grant0) begin
            alu_in1 = req0_in1;
            alu_in2 = req0_in2;
            alu_op  = req0_op;
        end else if (grant1) begin
            alu_in1 = req1_in1;
            alu_in2 = req1_in2;
            alu_op  = req1_op;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_q        <= 1'b1;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            resp0_data_q  <= '0;
            resp1_data_q  <= '0;
        end else begin
            if (grant0) begin
                resp0_valid_q <= 1'b1;
                resp0_data_q  <= alu_out;
            end else if (resp0_ready) begin
                resp0_valid_q <= 1'b0;
            end

            if (grant1) begin
                resp1_valid_q <= 1'b1;
                resp1_data_q  <= alu_out;
            end else if (resp1_ready) begin
                resp1_valid_q <= 1'b0;
            end

            if (grant0) begin
                last_q <= 1'b0;
            end else if (grant1) begin
                last_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU on the shared port.
module tb_alu_arbiter;

    logic        clock;
    logic        reset;
    logic        req0_valid, req0_ready, resp0_valid, resp0_ready;
    logic [9:0]  req0_op;
    logic [31:0] req0_in1, req0_in2, resp0_data;
    logic        req1_valid, req1_ready, resp1_valid, resp1_ready;
    logic [9:0]  req1_op;
    logic [31:0] req1_in1, req1_in2, resp1_data;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic [9:0]  alu_op;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic        g0, g1;
    logic [9:0]  aop;
    logic [31:0] ain1;
    logic [31:0] exp_v;

    alu_arbiter #(.WIDTH(32), .OP_WIDTH(10)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_in1(req0_in1), .req0_in2(req0_in2),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_in1(req1_in1), .req1_in2(req1_in2),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_out(alu_out)
    );

    function automatic logic [31:0] alu_fn(input logic [9:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] r;
        r = '0;
        case (1'b1)
            op[0]: r = a + b;
            op[1]: r = a - b;
            op[2]: r = a & b;
            op[3]: r = a | b;
            op[4]: r = a ^ b;
            op[5]: r = a << b[4:0];
            op[6]: r = a >> b[4:0];
            op[7]: r = $unsigned($signed(a) >>> b[4:0]);
            op[8]: r = {31'b0, $signed(a) < $signed(b)};
            op[9]: r = {31'b0, a < b};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb alu_out = alu_fn(alu_op, alu_in1, alu_in2);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Samples grant/ALU drive at negedge, queues expected results, then steps past the posedge.
    task automatic tick();
        @(negedge clock);
        g0   = req0_ready;
        g1   = req1_ready;
        aop  = alu_op;
        ain1 = alu_in1;
        if (g0) q0.push_back(alu_fn(req0_op, req0_in1, req0_in2));
        if (g1) q1.push_back(alu_fn(req1_op, req1_in1, req1_in2));
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0;
        req0_op = '0; req1_op = '0;
        req0_in1 = '0; req0_in2 = '0; req1_in1 = '0; req1_in2 = '0;
        resp0_ready = 1; resp1_ready = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        req0_valid = 1; req0_op = 10'b1; req0_in1 = 32'd1; req0_in2 = 32'd2;
        req1_valid = 1; req1_op = 10'b10000; req1_in1 = 32'hAA;
        tick();
        n_cmp++; if (g0 !== 1'b0 || g1 !== 1'b0) begin n_err++;
            $display("FAIL reset_ready: got %b%b want 00", g0, g1); end
        n_cmp++; if (aop !== 10'b0 || ain1 !== 32'b0) begin n_err++;
            $display("FAIL reset_alu: got op %h in1 %h want 0 0", aop, ain1); end
        tick();
        n_cmp++; if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_valid: got %b%b want 00", resp0_valid, resp1_valid); end
        n_cmp++; if (resp0_data !== 32'd0 || resp1_data !== 32'd0) begin n_err++;
            $display("FAIL reset_data: got %h %h want 0 0", resp0_data, resp1_data); end
        idle_inputs();
        reset = 0;
    endtask

    task automatic test_single();
        req0_valid = 1; req0_op = 10'b1; req0_in1 = 32'd5; req0_in2 = 32'd7;
        tick();
        n_cmp++; if (g0 !== 1'b1 || aop !== 10'b1) begin n_err++;
            $display("FAIL single_grant: got ready %b op %h want 1 001", g0, aop); end
        exp_v = (q0.size() != 0) ? q0.pop_front() : 'x;
        n_cmp++; if (resp0_valid !== 1'b1 || resp0_data !== 32'd12 || exp_v !== 32'd12) begin
            n_err++;
            $display("FAIL single_resp: got %b %0d want 1 12", resp0_valid, resp0_data); end
        n_cmp++; if (resp1_valid !== 1'b0) begin n_err++;
            $display("FAIL single_resp1: got %b want 0", resp1_valid); end
        req0_valid = 0;
        tick();
        n_cmp++; if (resp0_valid !== 1'b0 || resp0_data !== 32'd12) begin n_err++;
            $display("FAIL single_drain: got %b %0d want 0 12", resp0_valid, resp0_data); end
    endtask

    task automatic test_tie();
        reset = 1;
        tick();
        reset = 0;
        req0_valid = 1; req0_op = 10'b10; req0_in1 = 32'd10; req0_in2 = 32'd3;
        req1_valid = 1; req1_op = 10'b10000; req1_in1 = 32'hF0; req1_in2 = 32'h0F;
        tick();
        n_cmp++; if (g0 !== 1'b1 || g1 !== 1'b0) begin n_err++;
            $display("FAIL tie_c0: got %b%b want 10", g0, g1); end
        exp_v = (q0.size() != 0) ? q0.pop_front() : 'x;
        n_cmp++; if (resp0_data !== 32'd7 || exp_v !== 32'd7) begin n_err++;
            $display("FAIL tie_r0: got %0d want 7", resp0_data); end
        req0_valid = 0;
        tick();
        n_cmp++; if (g1 !== 1'b1 || g0 !== 1'b0) begin n_err++;
            $display("FAIL tie_c1: got %b%b want 01", g0, g1); end
        exp_v = (q1.size() != 0) ? q1.pop_front() : 'x;
        n_cmp++; if (resp1_valid !== 1'b1 || resp1_data !== 32'hFF || exp_v !== 32'hFF) begin
            n_err++;
            $display("FAIL tie_r1: got %b %h want 1 ff", resp1_valid, resp1_data); end
        idle_inputs();
        tick();
    endtask

    task automatic test_fairness();
        logic [31:0] e;
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 6; i++) begin
            req0_op = 10'b1 << $urandom_range(0, 9); req0_in1 = $urandom; req0_in2 = $urandom;
            req1_op = 10'b1 << $urandom_range(0, 9); req1_in1 = $urandom; req1_in2 = $urandom;
            tick();
            n_cmp++; if (g0 !== (i % 2 == 0) || g1 !== (i % 2 == 1)) begin n_err++;
                $display("FAIL fair_grant%0d: got %b%b want %b%b", i, g0, g1,
                         i % 2 == 0, i % 2 == 1); end
            if (i % 2 == 0) begin
                e = (q0.size() != 0) ? q0.pop_front() : 'x;
                n_cmp++; if (resp0_valid !== 1'b1 || resp0_data !== e) begin n_err++;
                    $display("FAIL fair_r0_%0d: got %h want %h", i, resp0_data, e); end
            end else begin
                e = (q1.size() != 0) ? q1.pop_front() : 'x;
                n_cmp++; if (resp1_valid !== 1'b1 || resp1_data !== e) begin n_err++;
                    $display("FAIL fair_r1_%0d: got %h want %h", i, resp1_data, e); end
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_backpressure();
        resp0_ready = 0;
        req0_valid = 1; req0_op = 10'b100; req0_in1 = 32'hFF00FF00; req0_in2 = 32'h0FF00FF0;
        tick();
        n_cmp++; if (g0 !== 1'b1) begin n_err++;
            $display("FAIL bp_first: got %b want 1", g0); end
        exp_v = (q0.size() != 0) ? q0.pop_front() : 'x;
        n_cmp++; if (resp0_valid !== 1'b1 || resp0_data !== 32'h0F000F00 || exp_v !== 32'h0F000F00)
        begin n_err++;
            $display("FAIL bp_r1: got %b %h want 1 0f000f00", resp0_valid, resp0_data); end
        req0_op = 10'b1000; req0_in1 = 32'h12340000; req0_in2 = 32'h00005678;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (g0 !== 1'b0) begin n_err++;
                $display("FAIL bp_block%0d: got %b want 0", i, g0); end
            n_cmp++; if (resp0_valid !== 1'b1 || resp0_data !== 32'h0F000F00) begin n_err++;
                $display("FAIL bp_hold%0d: got %b %h want 1 0f000f00", i, resp0_valid,
                         resp0_data); end
        end
        resp0_ready = 1;
        tick();
        n_cmp++; if (g0 !== 1'b1) begin n_err++;
            $display("FAIL bp_pass: got %b want 1", g0); end
        exp_v = (q0.size() != 0) ? q0.pop_front() : 'x;
        n_cmp++; if (resp0_valid !== 1'b1 || resp0_data !== 32'h12345678 || exp_v !== 32'h12345678)
        begin n_err++;
            $display("FAIL bp_r2: got %b %h want 1 12345678", resp0_valid, resp0_data); end
        idle_inputs();
        tick();
    endtask

    task automatic test_starvation();
        logic [31:0] e;
        resp1_ready = 0;
        req1_valid = 1; req1_op = 10'b100000; req1_in1 = 32'd3; req1_in2 = 32'd4;
        tick();
        exp_v = (q1.size() != 0) ? q1.pop_front() : 'x;
        n_cmp++; if (g1 !== 1'b1 || resp1_valid !== 1'b1 || resp1_data !== 32'd48) begin
            n_err++;
            $display("FAIL starve_fill: got %b %b %0d want 1 1 48", g1, resp1_valid, resp1_data);
        end
        req0_valid = 1;
        for (int i = 0; i < 4; i++) begin
            req0_op = 10'b1 << i; req0_in1 = 32'd100 + i; req0_in2 = 32'd2;
            tick();
            n_cmp++; if (g0 !== 1'b1 || g1 !== 1'b0 || aop !== req0_op) begin n_err++;
                $display("FAIL starve_grant%0d: got %b%b op %h want 10 op %h", i, g0, g1, aop,
                         req0_op); end
            e = (q0.size() != 0) ? q0.pop_front() : 'x;
            n_cmp++; if (resp0_data !== e || resp1_valid !== 1'b1 || resp1_data !== exp_v) begin
                n_err++;
                $display("FAIL starve_resp%0d: got %h %b %h want %h 1 %h", i, resp0_data,
                         resp1_valid, resp1_data, e, exp_v); end
        end
        idle_inputs();
        tick();
        n_cmp++; if (resp1_valid !== 1'b0) begin n_err++;
            $display("FAIL starve_drain: got %b want 0", resp1_valid); end
    endtask

    task automatic test_reset_mid();
        resp1_ready = 0;
        req1_valid = 1; req1_op = 10'b1; req1_in1 = 32'd20; req1_in2 = 32'd22;
        tick();
        n_cmp++; if (resp1_valid !== 1'b1 || resp1_data !== 32'd42) begin n_err++;
            $display("FAIL mid_capture: got %b %0d want 1 42", resp1_valid, resp1_data); end
        q1.delete();
        reset = 1;
        tick();
        n_cmp++; if (resp1_valid !== 1'b0 || resp1_data !== 32'd0) begin n_err++;
            $display("FAIL mid_clear: got %b %0d want 0 0", resp1_valid, resp1_data); end
        q0.delete();
        q1.delete();
        reset = 0;
        resp1_ready = 1;
        req0_valid = 1; req0_op = 10'b10; req0_in1 = 32'd9; req0_in2 = 32'd10;
        tick();
        n_cmp++; if (g0 !== 1'b1 || g1 !== 1'b0) begin n_err++;
            $display("FAIL mid_tie: got %b%b want 10", g0, g1); end
        exp_v = (q0.size() != 0) ? q0.pop_front() : 'x;
        n_cmp++; if (resp0_data !== 32'hFFFFFFFF || exp_v !== 32'hFFFFFFFF) begin n_err++;
            $display("FAIL mid_r0: got %h want ffffffff", resp0_data); end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        test_reset();
        test_single();
        test_tie();
        test_fairness();
        test_backpressure();
        test_starvation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters, e.g. the execute path and a future address-generation or multi-cycle unit.
- Each requester issues operations over a valid/ready handshake and receives its result through a one-entry response register with its own valid/ready handshake.
- Arbitration is round-robin. The block drives the shared ALU's in1/in2/op ports and samples its out port.

Parameters:
- WIDTH, 32, operand and result width.
- OP_WIDTH, 10, ALU one-hot op width (LSB to MSB: + - & | ^ << >> >>> < LTU).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle (when valid).
- req0_op  in  OP_WIDTH  requester 0 one-hot ALU op.
- req0_in1  in  WIDTH  requester 0 first operand.
- req0_in2  in  WIDTH  requester 0 second operand.
- resp0_valid  out  1  requester 0 result available.
- resp0_ready  in  1  requester 0 consumes result.
- resp0_data  out  WIDTH  requester 0 result.
- req1_valid, req1_ready, req1_op, req1_in1, req1_in2, resp1_valid, resp1_ready, resp1_data: identical definitions for requester 1.
- alu_in1  out  WIDTH  to shared ALU in1.
- alu_in2  out  WIDTH  to shared ALU in2.
- alu_op  out  OP_WIDTH  to shared ALU op.
- alu_out  in  WIDTH  from shared ALU out.

Behaviour:
- Clocking: single clock; synchronous, active-high reset.
- Reset values: resp0_valid = resp1_valid = 0; resp0_data = resp1_data = 0; round-robin pointer last = 1, so requester 0 wins the first tie. While reset is high: req0_ready = req1_ready = 0, alu_op = 0, alu_in1 = alu_in2 = 0.
- Eligibility: eligible_i = req_i_valid & (!resp_i_valid | resp_i_ready). A full response slot that is drained in the same cycle counts as free (pass-through).
- Grant, combinational, at most one per cycle:
  - Only one requester eligible: grant it.
  - Both eligible: grant the requester != last.
  - Neither eligible: no grant.
- req_i_ready = grant_i. Ready depends on both requesters' valids; requesters must not make valid depend on ready.
- ALU drive:
  - On grant_i: alu_in1/alu_in2/alu_op = req_i_in1/in2/op in the same cycle.
  - No grant: alu_op = 0 and operands = 0 (ALU outputs 0; no spurious activity).
- Capture on a posedge with grant_i: resp_i_data <= alu_out, resp_i_valid <= 1, last <= i. Latency: result visible exactly 1 cycle after acceptance.
- Drain: on a posedge with resp_i_valid & resp_i_ready and no new grant_i, resp_i_valid <= 0. resp_i_data holds its last value.
- Simultaneous drain and grant to the same requester: resp_i_valid stays 1 and resp_i_data takes the new result.
- Hold: resp_i_valid and resp_i_data are stable while resp_i_ready = 0.
- No grant: last is unchanged.
- Starvation: a requester with a blocked response slot is ineligible, so the other requester receives every grant meanwhile. Round-robin bounds wait to 1 grant otherwise.
- Reset mid-operation: any captured or in-flight result is discarded; all state returns to reset values on the next posedge.
- Arithmetic: the block performs no arithmetic itself; results are whatever alu_out returns, at full WIDTH, unmodified.
- Shape: grant logic, two response registers, one pointer bit. No other state.

Test Plan:
- Single request: reset, then req0 op=add (10'b1), in1=5, in2=7, one cycle → req0_ready=1 that cycle; alu_op=10'b1; resp0_valid=1, resp0_data=12 next cycle; resp1_valid stays 0.
- Tie after reset: both valid at cycle 0 (req0 sub 10−3; req1 xor 0xF0^0x0F), resp readys=1 → cycle 0 grants 0, cycle 1 grants 1; resp0_data=7 at cycle 1; resp1_data=0xFF at cycle 2.
- Fairness: both valid continuously 6 cycles, resp readys=1 → grant sequence 0,1,0,1,0,1; never two consecutive grants to one requester.
- Backpressure: resp0_ready=0, req0 issues and1 then or2 → first accepted; req0_ready=0 while resp0_valid=1 and data held. Raise resp0_ready → second accepted that same cycle; resp0_valid stays 1 with the new result.
- Starvation: resp1 blocked with resp1_valid=1, both requesting → req0 granted every cycle; alu_op matches req0_op each cycle; req1_ready=0 throughout.
- Reset mid-operation: accept req1 op, assert reset on the following cycle → resp1_valid=0 and resp1_data=0 after that edge. Both request post-reset → requester 0 wins.
